// File: rtl/burt_v_window_gen_fp16.sv
// burt_v_window_gen_fp16
//   Builds the WINDOW_HEIGHT x 1 vertical window for the vertical Burt convolution
//   from a raster fp16 pixel stream. It uses a cascade of WINDOW_HEIGHT-1 line
//   buffers, and the data path has one cycle of latency. There is no backpressure.
//   Optional build macro: BURT_WINDOW_SEQ_CHECK_EN enables raster-order checking
//   and drives error_o. With the macro undefined, error_o is tied to 0.
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   pixel_i          input pixel (opaque bits)
//   col_i, row_i     input coordinates
//   valid_i          input qualifier
//   window_o         window_o[0][0] = oldest row, window_o[H-1][0] = current pixel
//   col_o, row_o     centre coordinates
//   valid_o          window qualifier
//   error_o          sticky sequence error
module burt_v_window_gen_fp16 #(
  parameter int unsigned EXP_WIDTH     = 5,
  parameter int unsigned FRAC_WIDTH    = 10,
  parameter int unsigned WINDOW_HEIGHT = 9,
  parameter int unsigned WINDOW_WIDTH  = 1,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                   pixel_i,
  input  logic [15:0]                                               col_i,
  input  logic [15:0]                                               row_i,
  input  logic                                                      valid_i,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]                                               col_o,
  output logic [15:0]                                               row_o,
  output logic                                                      valid_o,
  output logic                                                      error_o
);

  localparam int unsigned LB_COUNT = WINDOW_HEIGHT - 1;
  localparam int unsigned HALF     = (WINDOW_HEIGHT - 1) / 2;
  localparam int unsigned ADDR_W   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RF_W     = $clog2(WINDOW_HEIGHT);
  localparam logic [RF_W-1:0] RF_FULL  = RF_W'(WINDOW_HEIGHT - 1);
  localparam logic [15:0]     LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]     LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  // Reject configurations the window cascade cannot represent.
  if (WINDOW_WIDTH != 1 || WINDOW_HEIGHT < 3 || (WINDOW_HEIGHT % 2) == 0 ||
      IMAGE_HEIGHT < WINDOW_HEIGHT) begin : g_cfg_err
    $error("burt_v_window_gen_fp16: unsupported window/image configuration");
  end

  logic [FP_WIDTH_REG-1:0] lb      [LB_COUNT][IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] lb_rd_c [LB_COUNT];
  logic [ADDR_W-1:0]       addr_c;
  logic                    frame_start_c;
  logic                    row_end_c;
  logic                    seq_err_c;
  logic [RF_W-1:0]         rows_filled_q;
  logic [RF_W-1:0]         rows_base_c;
  logic [RF_W-1:0]         rows_next_c;
  logic                    valid_next_c;

  assign addr_c        = col_i[ADDR_W-1:0];
  assign frame_start_c = valid_i && (col_i == 16'd0) && (row_i == 16'd0);
  assign row_end_c     = valid_i && (col_i == LAST_COL);

  // Read all line buffers at the current column; the old contents feed both the window and the shift.
  always_comb begin
    for (int k = 0; k < int'(LB_COUNT); k++) begin
      lb_rd_c[k] = lb[k][addr_c];
    end
  end

  // Line-buffer cascade: the new pixel enters lb[0], and each older row moves down one buffer. No reset (RAM).
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      lb[0][addr_c] <= pixel_i;
      for (int k = 1; k < int'(LB_COUNT); k++) begin
        lb[k][addr_c] <= lb_rd_c[k-1];
      end
    end
  end

`ifdef BURT_WINDOW_SEQ_CHECK_EN
  logic [15:0] exp_col_q;
  logic [15:0] exp_row_q;

  // (0,0) always resynchronises. Any other coordinate must match the raster prediction.
  assign seq_err_c = valid_i && !frame_start_c &&
                     ((col_i != exp_col_q) || (row_i != exp_row_q));

  // Predict the next raster coordinate from the one received; this also resyncs after an error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_col_q <= '0;
      exp_row_q <= '0;
      error_o   <= 1'b0;
    end else begin
      if (valid_i) begin
        if (col_i >= LAST_COL) begin
          exp_col_q <= '0;
          exp_row_q <= (row_i >= LAST_ROW) ? 16'd0 : row_i + 16'd1;
        end else begin
          exp_col_q <= col_i + 16'd1;
          exp_row_q <= row_i;
        end
      end
      if (seq_err_c) begin
        error_o <= 1'b1;
      end
    end
  end
`else
  assign seq_err_c = 1'b0;
  assign error_o   = 1'b0;
`endif

  // Row accounting: a clear (frame start or sequence error) comes before the row-end increment.
  always_comb begin
    rows_base_c = rows_filled_q;
    if (frame_start_c || seq_err_c) begin
      rows_base_c = '0;
    end
    rows_next_c = rows_base_c;
    if (row_end_c && (rows_base_c != RF_FULL)) begin
      rows_next_c = rows_base_c + RF_W'(1);
    end
    valid_next_c = valid_i && !seq_err_c && (rows_base_c == RF_FULL);
  end

  // Output registers. The window and coordinates hold their values unless a window is emitted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_filled_q <= '0;
      valid_o       <= 1'b0;
      window_o      <= '0;
      col_o         <= '0;
      row_o         <= '0;
    end else begin
      rows_filled_q <= rows_next_c;
      valid_o       <= valid_next_c;
      if (valid_next_c) begin
        window_o[WINDOW_HEIGHT-1][0] <= pixel_i;
        for (int k = 0; k < int'(LB_COUNT); k++) begin
          window_o[int'(LB_COUNT)-1-k][0] <= lb_rd_c[k];
        end
        col_o <= col_i;
        row_o <= row_i - 16'(HALF);
      end
    end
  end

endmodule

// File: tb/tb_burt_v_window_gen_fp16.sv
// Testbench for burt_v_window_gen_fp16 (H=9, IMAGE_WIDTH=8, IMAGE_HEIGHT=12).
// A reference model scores each driven pixel. Expected windows are queued and
// then compared when valid_o is seen.
module tb_burt_v_window_gen_fp16;
  localparam int H   = 9;
  localparam int W   = 8;
  localparam int IH  = 12;
  localparam int FPW = 16;

  logic                          clk = 1'b0;
  logic                          rst_i = 1'b1;
  logic [FPW-1:0]                pixel_i = '0;
  logic [15:0]                   col_i = '0;
  logic [15:0]                   row_i = '0;
  logic                          valid_i = 1'b0;
  logic [H-1:0][0:0][FPW-1:0]    window_o;
  logic [15:0]                   col_o;
  logic [15:0]                   row_o;
  logic                          valid_o;
  logic                          error_o;

  burt_v_window_gen_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_HEIGHT(H), .WINDOW_WIDTH(1),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(IH)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .pixel_i(pixel_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .window_o(window_o), .col_o(col_o), .row_o(row_o),
    .valid_o(valid_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]             cyc;
    logic [15:0]             col;
    logic [15:0]             row;
    logic [H-1:0][FPW-1:0]   win;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pulses = 0;
  bit          first_arm = 1'b0;

  // Reference model state
  int          m_rows = 0;
  int          m_ec = 0;
  int          m_er = 0;
  logic        m_err = 1'b0;
  logic        m_err_d = 1'b0;
  logic [FPW-1:0] colh [W][H-1];

`ifdef BURT_WINDOW_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fp(input int v);
    int e;
    int m;
    if (v == 0) return 16'h0000;
    e = 0;
    for (int i = 0; i < 11; i++) if (v >= (1 << i)) e = i;
    m = (v << (10 - e)) & 32'h3ff;
    return {1'b0, 5'(e + 15), 10'(m)};
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_err_d <= rst_i ? 1'b0 : m_err;
  end

  // Monitor: pop and compare each emitted window, and track error_o.
  always @(negedge clk) begin
    exp_t e;
    chk("error_o", 32'(error_o), 32'(m_err_d));
    if (valid_o) begin
      pulses++;
      if (first_arm) begin
        first_arm = 1'b0;
        chk("first_col", 32'(col_o), 0);
        chk("first_row", 32'(row_o), 4);
        for (int k = 0; k < H; k++) chk($sformatf("first_win%0d", k), 32'(window_o[k][0]), 32'(fp(k * 8)));
      end
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'(1), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk("latency", 32'(cyc), e.cyc + 32'd1);
        chk("col_o", 32'(col_o), 32'(e.col));
        chk("row_o", 32'(row_o), 32'(e.row));
        for (int k = 0; k < H; k++) chk($sformatf("win%0d", k), 32'(window_o[k][0]), 32'(e.win[k]));
      end
    end
  end

  task automatic send(input logic [FPW-1:0] pix, input int c, input int r, input logic v);
    bit   fs;
    bit   seq;
    int   base;
    exp_t e;
    @(negedge clk);
    pixel_i = pix; col_i = 16'(c); row_i = 16'(r); valid_i = v;
    if (v) begin
      fs  = (c == 0) && (r == 0);
      seq = 1'b0;
      if (SEQ_EN) begin
        seq = !fs && ((c != m_ec) || (r != m_er));
        if (c == W - 1) begin
          m_ec = 0;
          m_er = (r == IH - 1) ? 0 : r + 1;
        end else begin
          m_ec = c + 1;
          m_er = r;
        end
        if (seq) m_err = 1'b1;
      end
      base = (fs || seq) ? 0 : m_rows;
      if (base == H - 1 && !seq) begin
        e.cyc = 32'(cyc);
        e.col = 16'(c);
        e.row = 16'(r - (H - 1) / 2);
        e.win[H-1] = pix;
        for (int k = 0; k < H - 1; k++) e.win[H-2-k] = colh[c][k];
        sbq.push_back(e);
      end
      for (int k = H - 2; k > 0; k--) colh[c][k] = colh[c][k-1];
      colh[c][0] = pix;
      m_rows = base;
      if (c == W - 1 && m_rows < H - 1) m_rows++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b0;
    m_rows = 0; m_ec = 0; m_er = 0; m_err = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // One raster frame. The reset and skip coordinates are optional (-1 = none).
  task automatic frame(input int base, input bit toggle, input int rc, input int rr,
                       input int sc, input int sr);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < W; c++) begin
        if (c == rc && r == rr) do_reset();
        if (!(c == sc && r == sr)) begin
          send(fp(base + r * 8 + c), c, r, 1'b1);
          if (toggle) send('0, 0, 0, 1'b0);
        end
      end
    end
    send('0, 0, 0, 1'b0);
    send('0, 0, 0, 1'b0);
    #1;
  endtask

  initial begin
    for (int c = 0; c < W; c++) for (int k = 0; k < H - 1; k++) colh[c][k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Idle after reset: all outputs stay at zero
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_valid", 32'(valid_o), 0);
      chk("idle_win_nz", 32'(window_o != '0), 0);
      chk("idle_col", 32'(col_o), 0);
      chk("idle_row", 32'(row_o), 0);
      chk("idle_err", 32'(error_o), 0);
    end

    // Full frame
    pulses = 0; first_arm = 1'b1;
    frame(0, 1'b0, -1, -1, -1, -1);
    chk("pulses_full", 32'(pulses), 32);

    // Same frame with gapped valid
    pulses = 0;
    frame(0, 1'b1, -1, -1, -1, -1);
    chk("pulses_gapped", 32'(pulses), 32);

    // Reset at (3,9): only row 8 and (0..2,9) are emitted
    pulses = 0;
    frame(0, 1'b0, 3, 9, -1, -1);
    chk("pulses_rst_frame", 32'(pulses), 11);
    pulses = 0; first_arm = 1'b1;
    frame(0, 1'b0, -1, -1, -1, -1);
    chk("pulses_after_rst", 32'(pulses), 32);

    // Back-to-back frames with distinct data
    pulses = 0;
    frame(0, 1'b0, -1, -1, -1, -1);
    chk("pulses_b2b_a", 32'(pulses), 32);
    pulses = 0;
    frame(1000, 1'b0, -1, -1, -1, -1);
    chk("pulses_b2b_b", 32'(pulses), 32);

    // Skip pixel (5,2)
    pulses = 0;
    frame(0, 1'b0, -1, -1, 5, 2);
    chk("pulses_skip", 32'(pulses), SEQ_EN ? 32'd16 : 32'd32);
    repeat (3) @(negedge clk);
    #1;
    chk("error_sticky", 32'(error_o), SEQ_EN ? 32'd1 : 32'd0);

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
